// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, FSM state encoding and parity helper
// for the loopback UART transmitter (uart) and receiver (uart_rx).
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // odd=0 gives even parity (XOR of data), odd=1 gives its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: midpoint-sampling receiver with parity and stop-bit check.
// Ports:
//   clk, reset   system clock, async active-high reset
//   rx_line      serial input (idle high)
//   dout         last good byte; not cleared by reset, powers up at 0
//   ready        sticky: a parity-correct byte is on dout
//   parity_err   sticky: last frame failed parity or stop check
//
// state  | meaning
// IDLE   | waiting for the line to go low
// START  | counting to the start-bit midpoint, glitch re-check
// DATA   | sampling 8 data bits LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then commit or flag error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] dout,
  output logic                 ready,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);

  uart_state_e          state_q, state_d;
  cnt_t                 cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ready_q, ready_d;
  logic                 perr_q, perr_d;
  // dout survives reset, so it has its own reset-free register.
  logic [DATA_BITS-1:0] dout_q = '0;
  logic [DATA_BITS-1:0] dout_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    ready_d = ready_q;
    perr_d  = perr_q;
    dout_d  = dout_q;
    if (state_q != IDLE && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_line) begin
            state_d = START;
            cnt_d   = HALF_LAST;
            ready_d = 1'b0;
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (rx_line) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = BIT_LAST;
            idx_d   = 3'd0;
          end
        end
        DATA: begin
          shift_d = {rx_line, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_LAST;
          if (idx_q == 3'd7) state_d = PARITY;
          else               idx_d   = idx_q + 3'd1;
        end
        PARITY: begin
          par_d   = rx_line;
          state_d = STOP;
          cnt_d   = BIT_LAST;
        end
        STOP: begin
          state_d = IDLE;
          if (rx_line && (par_q == calc_parity(shift_q, PARITY_ODD))) begin
            dout_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ready_q <= ready_d;
      perr_q  <= perr_d;
    end
  end

  // Held during reset rather than merely left unreset, so a reset pulse
  // in the middle of a STOP sample can never commit a partial byte.
  always_ff @(posedge clk) begin
    if (!reset) dout_q <= dout_d;
  end

  assign dout       = dout_q;
  assign ready      = ready_q;
  assign parity_err = perr_q;

endmodule

// File: rtl/uart.sv
// uart: parity UART transmitter looped back into uart_rx.
// Ports:
//   clk, reset   system clock, async active-high reset
//   din, wr_en   byte and one-cycle strobe that starts a frame when idle
//   tx_busy      high for exactly 11*CLKS_PER_BIT cycles per frame
//   ready, dout, parity_err   receiver results (see uart_rx)
//
// state  | meaning
// IDLE   | line high, waiting for wr_en
// START  | driving the start bit (0)
// DATA   | driving data bits 0..7
// PARITY | driving the parity bit
// STOP   | driving the stop bit (1); tx_busy drops as it ends
module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx_busy,
  output logic                 ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BIT_LAST = cnt_t'(CLKS_PER_BIT - 1);

  uart_state_e          tx_state_q, tx_state_d;
  cnt_t                 tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 rx_line;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    if (tx_state_q != IDLE && tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (wr_en) begin
            tx_shift_d = din;
            tx_par_d   = calc_parity(din, PARITY_ODD);
            tx_busy_d  = 1'b1;
            tx_line_d  = 1'b0;
            tx_cnt_d   = BIT_LAST;
            tx_state_d = START;
          end
        end
        START: begin
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_idx_d   = 3'd0;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = DATA;
        end
        DATA: begin
          tx_cnt_d = BIT_LAST;
          if (tx_idx_q == 3'd7) begin
            tx_line_d  = tx_par_q;
            tx_state_d = PARITY;
          end else begin
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_idx_d   = tx_idx_q + 3'd1;
          end
        end
        PARITY: begin
          tx_line_d  = 1'b1;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = STOP;
        end
        STOP: begin
          tx_busy_d  = 1'b0;
          tx_state_d = IDLE;
        end
        default: tx_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign rx_line = tx_line_q;
  assign tx_busy = tx_busy_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY_ODD  (PARITY_ODD)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_line   (rx_line),
    .dout      (dout),
    .ready     (ready),
    .parity_err(parity_err)
  );

endmodule

// File: tb/tb_uart.sv
// tb_uart: even- and odd-parity instances driven by the same stimulus,
// checked every cycle against a frame-level model plus directed literals.
module tb_uart;

  localparam int CPB       = 8;
  localparam int FRAME_CYC = uart_pkg::FRAME_BITS * CPB;
  localparam int IDLE_LIM  = 20 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       corrupt_even = 1'b0;

  logic       busy_e, ready_e, perr_e, busy_o, ready_o, perr_o;
  logic [7:0] dout_e, dout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en),
    .tx_busy(busy_e), .ready(ready_e), .dout(dout_e), .parity_err(perr_e));

  uart #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en),
    .tx_busy(busy_o), .ready(ready_o), .dout(dout_o), .parity_err(perr_o));

  logic       s_busy[2], s_ready[2], s_perr[2], s_line[2];
  logic [7:0] s_dout[2];
  assign s_busy[0] = busy_e;   assign s_busy[1] = busy_o;
  assign s_ready[0] = ready_e; assign s_ready[1] = ready_o;
  assign s_perr[0] = perr_e;   assign s_perr[1] = perr_o;
  assign s_dout[0] = dout_e;   assign s_dout[1] = dout_o;
  assign s_line[0] = dut_even.tx_line_q;
  assign s_line[1] = dut_odd.tx_line_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is 11 bit slots of CPB cycles each; results
  // appear once the frame time has elapsed.
  logic        m_busy[2]    = '{1'b0, 1'b0};
  int          m_cnt[2]     = '{0, 0};
  logic [10:0] m_frame[2]   = '{11'h7FF, 11'h7FF};
  logic [7:0]  m_byte[2]    = '{8'h00, 8'h00};
  logic [7:0]  m_dout[2]    = '{8'h00, 8'h00};
  logic        m_ready[2]   = '{1'b0, 1'b0};
  logic        m_perr[2]    = '{1'b0, 1'b0};
  logic        m_corrupt[2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k]  = 1'b0;
        m_cnt[k]   = 0;
        m_ready[k] = 1'b0;
        m_perr[k]  = 1'b0;
      end else if (m_busy[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == FRAME_CYC) begin
          m_busy[k] = 1'b0;
          if (m_corrupt[k]) m_perr[k] = 1'b1;
          else begin
            m_ready[k] = 1'b1;
            m_dout[k]  = m_byte[k];
          end
        end
      end else if (wr_en) begin
        m_busy[k]    = 1'b1;
        m_cnt[k]     = 0;
        m_byte[k]    = din;
        m_frame[k]   = {1'b1, (^din) ^ (k == 1), din, 1'b0};
        m_corrupt[k] = (k == 0) && corrupt_even;
        m_ready[k]   = 1'b0;
        m_perr[k]    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(s_busy[k]), 32'(m_busy[k]));
      chk($sformatf("line%0d", k), 32'(s_line[k]),
          32'(m_busy[k] ? m_frame[k][m_cnt[k] / CPB] : 1'b1));
      if (!m_busy[k]) begin
        chk($sformatf("ready%0d", k), 32'(s_ready[k]), 32'(m_ready[k]));
        chk($sformatf("perr%0d", k), 32'(s_perr[k]), 32'(m_perr[k]));
        chk($sformatf("dout%0d", k), 32'(s_dout[k]), 32'(m_dout[k]));
      end else if (m_cnt[k] >= CPB && m_cnt[k] < 10 * CPB) begin
        chk($sformatf("ready_mid%0d", k), 32'(s_ready[k]), 32'(1'b0));
        chk($sformatf("perr_mid%0d", k), 32'(s_perr[k]), 32'(1'b0));
        chk($sformatf("dout_mid%0d", k), 32'(s_dout[k]), 32'(m_dout[k]));
      end
    end
  end

  task automatic write(input logic [7:0] b);
    @(posedge clk); #1;
    din = b;
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_e && n < IDLE_LIM) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_bound", 32'(n < IDLE_LIM), 32'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_e), 32'(0));
    chk("rst_line", 32'(dut_even.tx_line_q), 32'(1));
    chk("rst_ready", 32'(ready_e), 32'(0));
    chk("rst_perr", 32'(perr_e), 32'(0));
    chk("rst_dout", 32'(dout_e), 32'h00);
    reset = 1'b0;

    // single 00 byte: busy length and result
    write(8'h00);
    n = 0;
    while (busy_e && n < IDLE_LIM) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_len", 32'(n), 32'(88));
    repeat (2) @(posedge clk);
    #1;
    chk("b00_ready", 32'(ready_e), 32'(1));
    chk("b00_dout", 32'(dout_e), 32'h00);
    chk("b00_perr", 32'(perr_e), 32'(0));

    // A5: parity bit 0 on even instance, 1 on odd
    write(8'hA5);
    repeat (9 * CPB + CPB / 2 - 1) @(posedge clk);
    #1;
    chk("a5_par_even", 32'(dut_even.tx_line_q), 32'(0));
    chk("a5_par_odd", 32'(dut_odd.tx_line_q), 32'(1));
    wait_idle();
    chk("a5_dout_even", 32'(dout_e), 32'hA5);
    chk("a5_dout_odd", 32'(dout_o), 32'hA5);

    // second write mid-frame is dropped
    write(8'h3C);
    repeat (20) @(posedge clk);
    write(8'hFF);
    wait_idle();
    chk("drop_dout", 32'(dout_e), 32'h3C);
    repeat (CPB) @(posedge clk);
    #1;
    chk("drop_no_frame", 32'(busy_e), 32'(0));

    // reset inside DATA
    write(8'h77);
    repeat (3 * CPB) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_e), 32'(0));
    chk("midrst_line", 32'(dut_even.tx_line_q), 32'(1));
    chk("midrst_ready", 32'(ready_e), 32'(0));
    chk("midrst_dout", 32'(dout_e), 32'h3C);
    @(posedge clk); #1;
    reset = 1'b0;
    write(8'h5A);
    wait_idle();
    chk("after_rst_dout", 32'(dout_e), 32'h5A);
    chk("after_rst_ready", 32'(ready_e), 32'(1));

    // flipped parity on the even instance's receive line (even parity of 01 is 1)
    corrupt_even = 1'b1;
    write(8'h01);
    corrupt_even = 1'b0;
    repeat (9 * CPB) @(posedge clk);
    #1;
    force dut_even.rx_line = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    release dut_even.rx_line;
    wait_idle();
    chk("perr_even", 32'(perr_e), 32'(1));
    chk("perr_ready_even", 32'(ready_e), 32'(0));
    chk("perr_dout_even", 32'(dout_e), 32'h5A);
    chk("perr_dout_odd", 32'(dout_o), 32'h01);
    chk("perr_ready_odd", 32'(ready_o), 32'(1));

    // full byte sweep with a reset pulse between frames
    for (int v = 0; v < 256; v++) begin
      write(8'(v));
      wait_idle();
      chk("sweep_dout", 32'(dout_e), 32'(v));
      chk("sweep_dout_odd", 32'(dout_o), 32'(v));
      reset_pulse();
      chk("sweep_hold", 32'(dout_e), 32'(v));
      chk("sweep_ready_clr", 32'(ready_e), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
